// File: rtl/axi_pkg.sv
// Shared AXI read-channel types: burst encodings, response codes, responder
// states and the latched AR request.
package axi_pkg;

  localparam int AXI_BEAT_BYTES = 8;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10
  } burst_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_BURST
  } rd_state_t;

  typedef struct packed {
    logic [63:0] addr;
    logic [7:0]  len;
    burst_t      burst;
    logic        err;
  } rd_req_t;

endpackage

// File: rtl/axi_rd_addr_gen.sv
// Next-beat address for a 64-bit AXI burst. The WRAP path exists only with
// AXI_RD_WRAP_EN defined; otherwise WRAP bursts are rejected upstream.
module axi_rd_addr_gen
  import axi_pkg::*;
(
  input  logic [63:0] addr,
  input  logic [7:0]  len,
  input  burst_t      burst,
  output logic [63:0] next_addr
);

  logic [63:0] incr;
  assign incr = addr + 64'(AXI_BEAT_BYTES);

`ifdef AXI_RD_WRAP_EN
  // len is 1/3/7/15 here, so {len,3'b111} is the wrap window size minus one.
  logic [63:0] wrap_mask;
  assign wrap_mask = {53'b0, len, 3'b111};

  always_comb begin
    next_addr = incr;
    if (burst == BURST_WRAP)
      next_addr = (addr & ~wrap_mask) | (incr & wrap_mask);
    else if (burst == BURST_FIXED)
      next_addr = addr;
  end
`else
  logic unused_len;
  assign unused_len = ^len;

  always_comb begin
    next_addr = incr;
    if (burst == BURST_FIXED)
      next_addr = addr;
  end
`endif

endmodule

// File: rtl/axi_rd_responder.sv
// AXI4 read responder over a word-addressed 64-bit store with a side write port.
// Optional AXI_RD_WRAP_EN enables WRAP bursts; without it WRAP returns SLVERR.
module axi_rd_responder
  import axi_pkg::*;
#(
  parameter int MEM_WORDS    = 4096,
  parameter int RESP_LATENCY = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         s_axi_arvalid,
  output logic                         s_axi_arready,
  input  logic [63:0]                  s_axi_araddr,
  input  logic [7:0]                   s_axi_arlen,
  input  logic [2:0]                   s_axi_arsize,
  input  logic [1:0]                   s_axi_arburst,
  output logic                         s_axi_rvalid,
  input  logic                         s_axi_rready,
  output logic [63:0]                  s_axi_rdata,
  output logic [1:0]                   s_axi_rresp,
  output logic                         s_axi_rlast,
  input  logic                         mem_we,
  input  logic [$clog2(MEM_WORDS)-1:0] mem_waddr,
  input  logic [63:0]                  mem_wdata,
  input  logic [7:0]                   mem_wstrb
);

  localparam int IW = $clog2(MEM_WORDS);

  rd_state_t   state, state_nxt;
  rd_req_t     req;
  logic [7:0]  cnt, lat_cnt, load_cnt;
  logic        rvalid_q, rlast_q;
  logic [63:0] rdata_q;
  logic [1:0]  rresp_q;
  logic [63:0] mem [MEM_WORDS];
  logic        arready, ar_hs, r_hs, load, ar_err, load_oor;
  logic [63:0] next_addr, load_addr;

  assign arready  = (state == ST_IDLE) && !reset;
  assign ar_hs    = s_axi_arvalid && arready;
  assign r_hs     = rvalid_q && s_axi_rready;
  assign load_oor = |load_addr[63:IW+3];

  always_comb begin
    ar_err = (s_axi_arsize != 3'b011);
    case (s_axi_arburst)
      2'b00, 2'b11: ar_err = 1'b1;
      2'b10: begin
`ifdef AXI_RD_WRAP_EN
        if (!(s_axi_arlen inside {8'd1, 8'd3, 8'd7, 8'd15})) ar_err = 1'b1;
`else
        ar_err = 1'b1;
`endif
      end
      default: ;
    endcase
  end

  axi_rd_addr_gen u_addr_gen (
    .addr      (req.addr),
    .len       (req.len),
    .burst     (req.burst),
    .next_addr (next_addr)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // BURST is entered with rvalid low; the first beat is fetched on the next
  // edge, which keeps the first-beat latency at RESP_LATENCY+1 for every setting.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    load_addr = req.addr;
    load_cnt  = cnt;
    case (state)
      ST_IDLE:  if (ar_hs) state_nxt = (RESP_LATENCY == 0) ? ST_BURST : ST_WAIT;
      ST_WAIT:  if (lat_cnt == 8'(RESP_LATENCY - 1)) state_nxt = ST_BURST;
      ST_BURST: begin
        if (!rvalid_q) begin
          load = 1'b1;
        end else if (s_axi_rready) begin
          if (cnt == 8'd0) begin
            state_nxt = ST_IDLE;
          end else begin
            load      = 1'b1;
            load_addr = next_addr;
            load_cnt  = cnt - 8'd1;
          end
        end
      end
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (mem_we)
      for (int b = 0; b < 8; b++)
        if (mem_wstrb[b]) mem[mem_waddr][b*8 +: 8] <= mem_wdata[b*8 +: 8];
  end

  // The store read here sees pre-write contents when a write lands on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      req      <= '0;
      cnt      <= '0;
      lat_cnt  <= '0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rresp_q  <= RESP_OKAY;
      rlast_q  <= 1'b0;
    end else begin
      if (ar_hs) begin
        req     <= '{addr: s_axi_araddr & ~64'h7, len: s_axi_arlen,
                     burst: burst_t'(s_axi_arburst), err: ar_err};
        cnt     <= s_axi_arlen;
        lat_cnt <= '0;
      end
      if (state == ST_WAIT) lat_cnt <= lat_cnt + 8'd1;
      if (load) begin
        rvalid_q <= 1'b1;
        rdata_q  <= (req.err || load_oor) ? 64'd0 : mem[load_addr[IW+2:3]];
        rresp_q  <= (req.err || load_oor) ? RESP_SLVERR : RESP_OKAY;
        rlast_q  <= (load_cnt == 8'd0);
        cnt      <= load_cnt;
        req.addr <= load_addr;
      end else if (r_hs) begin
        rvalid_q <= 1'b0;
        rdata_q  <= '0;
        rresp_q  <= RESP_OKAY;
        rlast_q  <= 1'b0;
      end
    end
  end

  assign s_axi_arready = arready;
  assign s_axi_rvalid  = rvalid_q && !reset;
  assign s_axi_rdata   = reset ? 64'd0 : rdata_q;
  assign s_axi_rresp   = reset ? 2'b00 : rresp_q;
  assign s_axi_rlast   = rlast_q && !reset;

endmodule

// File: tb/tb_axi_rd_responder.sv
// Scoreboard bench for axi_rd_responder: directed scenarios plus random bursts
// checked against a queue-based reference model of the store and burst rules.
module tb_axi_rd_responder;

  localparam int MW  = 256;
  localparam int LAT = 4;
  localparam int IW  = $clog2(MW);

  logic          clk = 0;
  logic          reset = 1;
  logic          s_axi_arvalid = 0, s_axi_arready;
  logic [63:0]   s_axi_araddr = 0;
  logic [7:0]    s_axi_arlen = 0;
  logic [2:0]    s_axi_arsize = 3;
  logic [1:0]    s_axi_arburst = 1;
  logic          s_axi_rvalid, s_axi_rready = 1, s_axi_rlast;
  logic [63:0]   s_axi_rdata;
  logic [1:0]    s_axi_rresp;
  logic          mem_we = 0;
  logic [IW-1:0] mem_waddr = 0;
  logic [63:0]   mem_wdata = 0;
  logic [7:0]    mem_wstrb = 0;

  axi_rd_responder #(.MEM_WORDS(MW), .RESP_LATENCY(LAT)) dut (
    .clk(clk), .reset(reset),
    .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
    .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp), .s_axi_rlast(s_axi_rlast),
    .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] data;
    logic [1:0]  resp;
    logic        last;
  } beat_t;

  beat_t       exp_q[$];
  logic [63:0] ref_mem [MW];
  int          n_cmp = 0, n_fail = 0;
  int          rr_mode = 0, rr_idx = 0;

  task automatic check(string nm, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Expected beats derived from the burst rules: beat i of INCR sits at base+8i,
  // beat i of WRAP sits inside the (len+1)*8-byte window containing base.
  function automatic void push_expected(logic [63:0] addr, int len, logic [2:0] size,
                                        logic [1:0] burst);
    bit err;
    longint unsigned base, sz, start, a, w;
    beat_t b;
    err = (size != 3'b011) || (burst == 2'b00) || (burst == 2'b11);
    if (burst == 2'b10) begin
`ifdef AXI_RD_WRAP_EN
      if (!(len == 1 || len == 3 || len == 7 || len == 15)) err = 1;
`else
      err = 1;
`endif
    end
    base  = addr & ~64'h7;
    sz    = longint'(len + 1) * 8;
    start = base - (base % sz);
    for (int i = 0; i <= len; i++) begin
      a = (burst == 2'b10) ? start + ((base - start + 8 * i) % sz) : base + 8 * i;
      w = a >> 3;
      if (err || w >= MW) begin
        b.data = 0;
        b.resp = 2'b10;
      end else begin
        b.data = ref_mem[w];
        b.resp = 2'b00;
      end
      b.last = (i == len);
      exp_q.push_back(b);
    end
  endfunction

  always @(posedge clk) begin
    #1;
    case (rr_mode)
      0:       s_axi_rready = 1;
      1:       s_axi_rready = 1'($urandom_range(0, 1));
      default: begin
        s_axi_rready = (rr_idx % 4 == 0) || (rr_idx % 4 == 3);
        rr_idx++;
      end
    endcase
  end

  // Monitor: pops the scoreboard on every R handshake, checks holds while stalled
  // and the AR-to-first-beat latency.
  int          cyc = 0, hs_cyc = 0;
  bit          first_pending = 0, stall_prev = 0;
  logic [63:0] pd;
  logic [1:0]  pr;
  logic        pl;
  beat_t       e;

  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      check("reset_ctrl", {60'b0, s_axi_arready, s_axi_rvalid, s_axi_rlast, s_axi_rresp != 0}, 64'd0);
      check("reset_rdata", s_axi_rdata, 64'd0);
      stall_prev    = 0;
      first_pending = 0;
    end else begin
      if (s_axi_rvalid) begin
        if (first_pending) begin
          check("first_latency", 64'(cyc - hs_cyc), 64'(LAT + 2));
          first_pending = 0;
        end
        if (stall_prev) begin
          check("held_rdata", s_axi_rdata, pd);
          check("held_resp_last", {61'b0, s_axi_rresp, s_axi_rlast}, {61'b0, pr, pl});
        end
        if (s_axi_rready) begin
          check("arready_overlap", {63'b0, s_axi_arready}, 64'd0);
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_beat: got data %h, expected no beat", s_axi_rdata);
          end else begin
            e = exp_q.pop_front();
            check("beat_rdata", s_axi_rdata, e.data);
            check("beat_resp_last", {61'b0, s_axi_rresp, s_axi_rlast}, {61'b0, e.resp, e.last});
          end
        end
        stall_prev = !s_axi_rready;
        pd = s_axi_rdata;
        pr = s_axi_rresp;
        pl = s_axi_rlast;
      end else begin
        stall_prev = 0;
      end
      if (s_axi_arvalid && s_axi_arready) begin
        hs_cyc        = cyc;
        first_pending = 1;
      end
    end
  end

  task automatic do_write(int idx, logic [63:0] d, logic [7:0] strb);
    @(posedge clk); #1;
    mem_we = 1; mem_waddr = IW'(idx); mem_wdata = d; mem_wstrb = strb;
    @(posedge clk); #1;
    mem_we = 0;
    for (int b = 0; b < 8; b++)
      if (strb[b]) ref_mem[idx][b*8 +: 8] = d[b*8 +: 8];
  endtask

  task automatic start_burst(logic [63:0] addr, int len, logic [2:0] size, logic [1:0] burst);
    bit ok = 0;
    push_expected(addr, len, size, burst);
    @(posedge clk); #1;
    s_axi_arvalid = 1; s_axi_araddr = addr; s_axi_arlen = 8'(len);
    s_axi_arsize = size; s_axi_arburst = burst;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (s_axi_arready) ok = 1;
    end
    if (!ok) begin
      n_cmp++;
      n_fail++;
      $display("FAIL ar_timeout: got arready=0 for 50 cycles, expected 1");
    end
    @(posedge clk); #1;
    s_axi_arvalid = 0;
  endtask

  task automatic wait_done(string nm);
    bit ok = 0;
    for (int i = 0; i < 2000 && !ok; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !s_axi_rvalid) ok = 1;
    end
    if (!ok) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s_timeout: got %0d beats outstanding, expected 0", nm, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic burst(logic [63:0] addr, int len, logic [2:0] size, logic [1:0] bt, string nm);
    start_burst(addr, len, size, bt);
    wait_done(nm);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 reset = 0;

    for (int i = 0; i < MW; i++) do_write(i, {$urandom, $urandom}, 8'hFF);
    for (int i = 0; i < 8; i++) do_write(16 + i, 64'hA0 + 64'(i), 8'hFF);

    rr_mode = 0;
    burst(64'h80, 7, 3'b011, 2'b01, "incr");
    rr_mode = 2; rr_idx = 0;
    burst(64'h80, 7, 3'b011, 2'b01, "backpressure");
    rr_mode = 0;
    burst(64'h18, 3, 3'b011, 2'b10, "wrap");
    burst(64'((MW - 1) * 8), 1, 3'b011, 2'b01, "range_end");
    burst(64'h80, 3, 3'b010, 2'b01, "bad_size");
    burst(64'h40, 2, 3'b011, 2'b00, "bad_burst");
    burst(64'h40, 2, 3'b011, 2'b10, "bad_wrap_len");

    // Write to word 0x11 on the edge that loads beat 2: beat 2 must be old data.
    start_burst(64'h80, 7, 3'b011, 2'b01);
    repeat (LAT + 1) @(posedge clk);
    #1 mem_we = 1; mem_waddr = IW'(17); mem_wdata = 64'h1122334455667788; mem_wstrb = 8'h0F;
    @(posedge clk); #1 mem_we = 0;
    ref_mem[17][31:0] = 32'h55667788;
    wait_done("collision");
    burst(64'h80, 7, 3'b011, 2'b01, "reread");

    // Reset while beat 3 of 8 is presented; remaining beats are abandoned.
    start_burst(64'h80, 7, 3'b011, 2'b01);
    repeat (LAT + 3) @(posedge clk);
    #1 reset = 1;
    exp_q.delete();
    @(posedge clk); #1 reset = 0;
    @(negedge clk);
    check("post_reset_ready", {62'b0, s_axi_arready, s_axi_rvalid}, 64'd2);
    burst(64'h80, 7, 3'b011, 2'b01, "after_reset");

    rr_mode = 1;
    for (int n = 0; n < 40; n++) begin
      int          len, r;
      logic [1:0]  bt;
      logic [2:0]  sz;
      logic [63:0] a;
      r  = $urandom_range(0, 9);
      bt = (r == 0) ? 2'b00 : (r == 1) ? 2'b11 : (r < 5) ? 2'b10 : 2'b01;
      if (bt == 2'b10 && $urandom_range(0, 3) != 0) len = (1 << $urandom_range(1, 4)) - 1;
      else len = $urandom_range(0, 15);
      sz = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 7)) : 3'b011;
      a  = {$urandom_range(0, MW + 8), 3'($urandom_range(0, 7))};
      if ($urandom_range(0, 2) == 0)
        do_write($urandom_range(0, MW - 1), {$urandom, $urandom}, 8'($urandom));
      burst(a, len, sz, bt, "random");
    end

    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
